// File: rtl/bus_arbiter_68020.sv
// 68020 bus arbitration controller: nBR/nBG/nBGACK handshake, protects
// in-flight and RMC cycles, drives the pin three-state enable and gates
// when the internal bus controller may start a new cycle.
module bus_arbiter_68020 #(
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       nBR,
  input  logic       nBGACK,
  input  logic       cpu_req,
  input  logic       cpu_cycle_done,
  input  logic       rmc_lock,
  output logic       cpu_gnt,
  output logic       nBG,
  output logic       bus_drive,
  output logic [2:0] arb_state
);

  typedef enum logic [2:0] {
    OWN   = 3'd0,
    BUSY  = 3'd1,
    GRANT = 3'd2,
    ALT   = 3'd3,
    TURN  = 3'd4
  } state_e;

  localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURNAROUND - 1);

  logic [SYNC_STAGES-1:0] br_sync_q;
  logic [SYNC_STAGES-1:0] bgack_sync_q;
  logic                   br_s;
  logic                   bgack_s;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   nbg_q, nbg_d;
  logic                   drive_q, drive_d;

  // Synchronize the asynchronous, active-low pins into active-high requests
  always_ff @(posedge CLK) begin
    if (RESET) begin
      br_sync_q    <= '0;
      bgack_sync_q <= '0;
    end else begin
      br_sync_q    <= {br_sync_q[SYNC_STAGES-2:0], ~nBR};
      bgack_sync_q <= {bgack_sync_q[SYNC_STAGES-2:0], ~nBGACK};
    end
  end

  assign br_s    = br_sync_q[SYNC_STAGES-1];
  assign bgack_s = bgack_sync_q[SYNC_STAGES-1];

  // State, turnaround counter and registered pin outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= OWN;
      cnt_q   <= '0;
      nbg_q   <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nbg_q   <= nbg_d;
      drive_q <= drive_d;
    end
  end

  // Next-state logic; nbg_d/drive_d decode the current state so the pins
  // follow the state one cycle after it is entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpu_gnt = 1'b0;
    nbg_d   = 1'b1;
    drive_d = 1'b0;
    unique case (state_q)
      OWN: begin
        drive_d = 1'b1;
        cpu_gnt = !br_s || rmc_lock;
        if (cpu_req && cpu_gnt) begin
          state_d = BUSY;
        end else if (br_s && !rmc_lock) begin
          state_d = GRANT;
        end
      end
      BUSY: begin
        drive_d = 1'b1;
        if (cpu_cycle_done) begin
          state_d = (br_s && !rmc_lock) ? GRANT : OWN;
        end
      end
      GRANT: begin
        nbg_d = 1'b0;
        if (bgack_s) begin
          state_d = ALT;
        end else if (!br_s) begin
          state_d = TURN;
          cnt_d   = TURN_LOAD;
        end
      end
      ALT: begin
        // keep the grant asserted while another master is queued
        nbg_d = !br_s;
        if (!bgack_s) begin
          if (br_s) begin
            state_d = GRANT;
          end else begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end
        end
      end
      TURN: begin
        if (bgack_s) begin
          state_d = ALT;
        end else if (cnt_q == '0) begin
          state_d = br_s ? GRANT : OWN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = OWN;
      end
    endcase
  end

  assign nBG       = nbg_q;
  assign bus_drive = drive_q;
  assign arb_state = state_q;

endmodule
